// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode, FSM state and control-bundle definitions for the hazard controller.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LUSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = ctrl_t'(6'b110100);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000001);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(6'b111110);
  localparam ctrl_t CTRL_LUSE   = ctrl_t'(6'b000110);
  localparam ctrl_t CTRL_RESET  = ctrl_t'(6'b000111);

endpackage

// File: rtl/hazard_ctrl_reg_use_decode.sv
// Source-register extraction and usage flags for the IF/ID instruction.
module reg_use_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic unused_bits;

  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign unused_bits = ^{instr[31:25], instr[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr[6:0])
      OPC_STORE, OPC_BRANCH, OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD, OPC_OPIMM, OPC_JALR: uses_rs1 = 1'b1;
      OPC_JAL, OPC_LUI, OPC_AUIPC:   uses_rs1 = 1'b0;
      default:                       uses_rs1 = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, memory-wait
// freeze, plus saturating stall/flush counters and a sticky memory-wait watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TMR_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic [31:0]      iInstrID,
  input  logic             iValidID,
  input  logic             iMemReadEX,
  input  logic             iRegWriteEX,
  input  logic [4:0]       iRdEX,
  input  logic             iBranchTakenEX,
  input  logic             iMemBusy,
  output logic             oPCWrite,
  output logic             oIFIDWrite,
  output logic             oIFIDFlush,
  output logic             oIDEXWrite,
  output logic             oIDEXBubble,
  output logic             oEXMEMHold,
  output logic [1:0]       oState,
  output logic [CNT_W-1:0] oStallCycles,
  output logic [CNT_W-1:0] oFlushCount,
  output logic             oMemTimeout
);

  state_e           state, state_nxt;
  ctrl_t            ctl;
  logic             flush_evt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             timeout;
  logic [4:0]       rs1, rs2;
  logic             uses_rs1, uses_rs2;
  logic             loaduse, lu_act, br_act;

  reg_use_decode u_decode (
    .instr    (iInstrID),
    .rs1      (rs1),
    .rs2      (rs2),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign loaduse = iValidID & iMemReadEX & iRegWriteEX & (iRdEX != 5'd0) &
                   ((uses_rs1 & (rs1 == iRdEX)) | (uses_rs2 & (rs2 == iRdEX)));
  // A stall or flush already in progress masks the hazards it is resolving.
  assign lu_act  = loaduse & (state != ST_LUSTALL) & (state != ST_FLUSH);
  assign br_act  = iBranchTakenEX & (state != ST_FLUSH);

  // Next state and Mealy controls; MEMWAIT without busy behaves exactly as RUN.
  always_comb begin
    ctl       = CTRL_RUN;
    state_nxt = ST_RUN;
    flush_evt = 1'b0;
    if (iMemBusy) begin
      ctl       = CTRL_FREEZE;
      state_nxt = ST_MEMWAIT;
    end else if (br_act) begin
      ctl       = CTRL_BRANCH;
      state_nxt = ST_FLUSH;
      flush_evt = 1'b1;
    end else if (lu_act) begin
      ctl       = CTRL_LUSE;
      state_nxt = ST_LUSTALL;
    end
    if (!iRST_n) ctl = CTRL_RESET;
  end

  // Wait timer restarts on MEMWAIT entry and saturates while waiting.
  always_comb begin
    timer_nxt = '0;
    if (state == ST_MEMWAIT) timer_nxt = (timer == '1) ? timer : timer + TMR_W'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= ST_RUN;
      timer     <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (iMemBusy) timer <= timer_nxt;
      if (iMemBusy && (timer_nxt == TMR_W'(MEM_TIMEOUT))) timeout <= 1'b1;
      if (!ctl.pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign oPCWrite     = ctl.pc_write;
  assign oIFIDWrite   = ctl.ifid_write;
  assign oIFIDFlush   = ctl.ifid_flush;
  assign oIDEXWrite   = ctl.idex_write;
  assign oIDEXBubble  = ctl.idex_bubble;
  assign oEXMEMHold   = ctl.exmem_hold;
  assign oState       = state;
  assign oStallCycles = stall_cnt;
  assign oFlushCount  = flush_cnt;
  assign oMemTimeout  = timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TMR_W       = 8;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instr;
  logic             valid, memrd, regwr, br, busy;
  logic [4:0]       rdex;
  logic             pcw, ifidw, ifidfl, idexw, bubble, hold;
  logic [1:0]       st;
  logic [CNT_W-1:0] stallc, flushc;
  logic             to;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TMR_W(TMR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iInstrID(instr), .iValidID(valid),
    .iMemReadEX(memrd), .iRegWriteEX(regwr), .iRdEX(rdex),
    .iBranchTakenEX(br), .iMemBusy(busy),
    .oPCWrite(pcw), .oIFIDWrite(ifidw), .oIFIDFlush(ifidfl), .oIDEXWrite(idexw),
    .oIDEXBubble(bubble), .oEXMEMHold(hold), .oState(st),
    .oStallCycles(stallc), .oFlushCount(flushc), .oMemTimeout(to)
  );

  always #5 clk = ~clk;

  // Expected control bundles {pcw, ifidw, ifidflush, idexw, bubble, hold}
  localparam logic [5:0] C_RUN    = 6'b110100;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_LUSE   = 6'b000110;
  localparam logic [5:0] C_RESET  = 6'b000111;

  function automatic logic [5:0] ctl_now();
    return {pcw, ifidw, ifidfl, idexw, bubble, hold};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_state, m_stall, m_flush, m_busy_run;
  bit m_to;

  function automatic bit hazard(input logic [31:0] ins, input logic v, input logic mr,
                                input logic rw, input logic [4:0] rd);
    logic [6:0] op;
    bit u1, u2;
    op = ins[6:0];
    u1 = op inside {7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h67};
    u2 = op inside {7'h23, 7'h63, 7'h33};
    return v && mr && rw && (rd != 0) &&
           ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
  endfunction

  task automatic set_in(input logic [31:0] i, input logic v, input logic mr, input logic rw,
                        input logic [4:0] rd, input logic b, input logic bz);
    instr = i; valid = v; memrd = mr; regwr = rw; rdex = rd; br = b; busy = bz;
  endtask

  task automatic idle();
    set_in(32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Asserted between clock edges; outputs must react with no clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl_now()), 32'(C_RESET));
    chk("rst_state", 32'(st), 0);
    chk("rst_stall", 32'(stallc), 0);
    chk("rst_flush", 32'(flushc), 0);
    chk("rst_timeout", 32'(to), 0);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_state = 0; m_stall = 0; m_flush = 0; m_busy_run = 0; m_to = 0;
  endtask

  // Inputs already applied at posedge+1; check controls, clock, check registers.
  task automatic step(input string nm, input logic [5:0] exp_ctl, input int exp_st,
                      input int exp_stall, input int exp_flush);
    #3;
    chk({nm, "_ctl"}, 32'(ctl_now()), 32'(exp_ctl));
    @(posedge clk); #1;
    chk({nm, "_state"}, 32'(st), 32'(exp_st));
    chk({nm, "_stall"}, 32'(stallc), 32'(exp_stall));
    chk({nm, "_flush"}, 32'(flushc), 32'(exp_flush));
  endtask

  // Random cycle checked against the behavioural model.
  task automatic model_cycle();
    logic [5:0] e;
    bit lu, b;
    int nxt;
    lu = hazard(instr, valid, memrd, regwr, rdex) && m_state != 1 && m_state != 3;
    b  = br && m_state != 3;
    if (busy) begin
      e = C_FREEZE; nxt = 2;
      if (m_stall < CNT_MAX) m_stall++;
      m_busy_run++;
      if (m_busy_run == MEM_TIMEOUT + 1) m_to = 1;
    end else begin
      m_busy_run = 0;
      if (b) begin
        e = C_BRANCH; nxt = 3;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (lu) begin
        e = C_LUSE; nxt = 1;
        if (m_stall < CNT_MAX) m_stall++;
      end else begin
        e = C_RUN; nxt = 0;
      end
    end
    m_state = nxt;
    step("rnd", e, m_state, m_stall, m_flush);
    chk("rnd_timeout", 32'(to), 32'(m_to));
  endtask

  typedef struct {
    logic [31:0] i;
    logic v, mr, rw;
    logic [4:0] rd;
    logic b, bz;
    logic [5:0] ctl;
    int nst;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;

    vecs.push_back('{32'h00728333, 1, 1, 1, 5'd5, 0, 0, C_LUSE,   1}); // add x6,x5,x7
    vecs.push_back('{32'h00000333, 1, 1, 1, 5'd0, 0, 0, C_RUN,    0}); // rd x0
    vecs.push_back('{32'h000002B7, 1, 1, 1, 5'd5, 0, 0, C_RUN,    0}); // lui
    vecs.push_back('{32'h00728333, 0, 1, 1, 5'd5, 0, 0, C_RUN,    0}); // bubble in ID
    vecs.push_back('{32'h00728333, 1, 1, 1, 5'd5, 1, 0, C_BRANCH, 3});
    vecs.push_back('{32'h00728333, 1, 1, 1, 5'd5, 1, 1, C_FREEZE, 2});
    vecs.push_back('{32'h00532023, 1, 1, 1, 5'd5, 0, 0, C_LUSE,   1}); // sw rs2=x5
    vecs.push_back('{32'h0002806F, 1, 1, 1, 5'd5, 0, 0, C_RUN,    0}); // jal, rs1 field=5
    vecs.push_back('{32'h00728333, 1, 0, 1, 5'd5, 0, 0, C_RUN,    0}); // not a load
    vecs.push_back('{32'h000280E7, 1, 1, 1, 5'd5, 0, 0, C_LUSE,   1}); // jalr rs1=x5
    vecs.push_back('{32'h0002A083, 1, 1, 1, 5'd5, 0, 0, C_LUSE,   1}); // lw rs1=x5
    vecs.push_back('{32'h00500063, 1, 1, 1, 5'd5, 0, 0, C_LUSE,   1}); // beq rs2=x5
    vecs.push_back('{32'h00728333, 1, 1, 0, 5'd5, 0, 0, C_RUN,    0}); // no regwrite
    vecs.push_back('{32'h0002A017, 1, 1, 1, 5'd5, 0, 0, C_RUN,    0}); // auipc

    foreach (vecs[k]) begin
      do_reset();
      set_in(vecs[k].i, vecs[k].v, vecs[k].mr, vecs[k].rw, vecs[k].rd, vecs[k].b, vecs[k].bz);
      step($sformatf("vec%0d", k), vecs[k].ctl, vecs[k].nst,
           (vecs[k].ctl[5] == 1'b0) ? 1 : 0, (vecs[k].nst == 3) ? 1 : 0);
    end

    // Load-use: exactly one bubble with inputs held
    do_reset();
    set_in(32'h00728333, 1, 1, 1, 5'd5, 0, 0);
    step("lu1", C_LUSE, 1, 1, 0);
    step("lu2", C_RUN, 0, 1, 0);

    // Branch wins over load-use; FLUSH masks both on the next cycle
    do_reset();
    set_in(32'h00728333, 1, 1, 1, 5'd5, 1, 0);
    step("br1", C_BRANCH, 3, 0, 1);
    step("br2", C_RUN, 0, 0, 1);

    // Busy freezes a pending branch, which then fires in the release cycle
    do_reset();
    set_in(32'h00000013, 1, 0, 0, 5'd0, 1, 1);
    step("mw1", C_FREEZE, 2, 1, 0);
    step("mw2", C_FREEZE, 2, 2, 0);
    step("mw3", C_FREEZE, 2, 3, 0);
    busy = 1'b0;
    step("mwrel", C_BRANCH, 3, 3, 1);

    // Watchdog: sets on the 5th busy edge with MEM_TIMEOUT=4, then sticky
    do_reset();
    set_in(32'h00000013, 1, 0, 0, 5'd0, 0, 1);
    for (int n = 1; n <= 6; n++) begin
      step($sformatf("wd%0d", n), C_FREEZE, 2, n, 0);
      chk($sformatf("wd%0d_timeout", n), 32'(to), (n >= 5) ? 1 : 0);
    end
    busy = 1'b0;
    step("wdidle1", C_RUN, 0, 6, 0);
    chk("wdidle1_timeout", 32'(to), 1);
    step("wdidle2", C_RUN, 0, 6, 0);
    chk("wdidle2_timeout", 32'(to), 1);
    busy = 1'b1;
    step("wdb1", C_FREEZE, 2, 7, 0);
    step("wdb2", C_FREEZE, 2, 8, 0);
    // Reset mid-MEMWAIT, away from any clock edge
    do_reset();
    chk("post_rst_state", 32'(st), 0);

    // Randomized traffic, long enough to saturate both counters
    begin
      logic [6:0] ops[10];
      ops = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};
      do_reset();
      for (int n = 0; n < 600; n++) begin
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(9)];
        ins[19:15] = 5'($urandom_range(7));
        ins[24:20] = 5'($urandom_range(7));
        set_in(ins, ($urandom_range(99) < 85), $urandom_range(1), ($urandom_range(3) != 0),
               5'($urandom_range(7)), ($urandom_range(99) < 12),
               ($urandom_range(99) < ((n % 200 < 30) ? 90 : 15)));
        model_cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
